// File: rtl/sigmoid_rr_sched.sv
// Round-robin front end that time-shares one sigmoid_taylor core among N_REQ
// requesters, with one transaction in flight from grant to response.
module sigmoid_rr_sched #(
  parameter int N_REQ = 4,
  parameter int DW    = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*DW-1:0]   req_x,
  output logic [N_REQ-1:0]      req_ready,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [DW-1:0]         rsp_fx,
  input  logic [N_REQ-1:0]      rsp_ready,
  output logic [DW-1:0]         core_x,
  input  logic [DW-1:0]         core_fx,
  output logic                  busy,
  output logic [15:0]           done_cnt
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, CALC, CAPT, RESP} state_t;

  state_t          state;
  logic [DW-1:0]   x_reg;
  logic [DW-1:0]   fx_reg;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   last_g;
  logic [IW-1:0]   winner;
  logic [IW-1:0]   cand;
  logic            found;
  logic [15:0]     cnt_q;

  // Search starts just past the last completed owner, so it ends up last in line.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IW'((int'(last_g) + k) % N_REQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Grant is gated by reset so every output shows its reset value while rst_n is low.
  assign req_ready = (rst_n && state == IDLE && found) ? (N_REQ'(1) << winner) : '0;
  assign rsp_valid = (state == RESP) ? (N_REQ'(1) << owner) : '0;
  assign rsp_fx    = (state == RESP) ? fx_reg : '0;
  assign busy      = (state != IDLE);
  assign core_x    = x_reg;
  assign done_cnt  = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      x_reg  <= '0;
      fx_reg <= '0;
      owner  <= '0;
      last_g <= IW'(N_REQ - 1);
      cnt_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            x_reg <= req_x[int'(winner)*DW +: DW];
            owner <= winner;
            state <= CALC;
          end
        end
        CALC: state <= CAPT;
        CAPT: begin
          fx_reg <= core_fx;
          state  <= RESP;
        end
        RESP: begin
          if (rsp_ready[owner]) begin
            last_g <= owner;
            cnt_q  <= cnt_q + 16'd1;
            state  <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sigmoid_rr_sched.sv
// Self-checking bench for sigmoid_rr_sched: transaction-level reference model
// checked every cycle, directed scenarios with literal expectations, random traffic.
module tb_sigmoid_rr_sched;

  localparam int N_REQ = 4;
  localparam int DW    = 12;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic [N_REQ-1:0]    req_valid = '0;
  logic [N_REQ*DW-1:0] req_x = '0;
  logic [N_REQ-1:0]    rsp_ready = '0;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    rsp_valid;
  logic [DW-1:0]       rsp_fx;
  logic [DW-1:0]       core_x;
  logic [DW-1:0]       core_fx = '0;
  logic                busy;
  logic [15:0]         done_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: one transaction, tracked by its age in cycles since grant.
  bit             m_active = 1'b0;
  int             m_owner  = 0;
  int             m_age    = 0;
  int             m_last   = N_REQ - 1;
  logic [DW-1:0]  m_x      = '0;
  logic [15:0]    m_cnt    = '0;

  sigmoid_rr_sched #(.N_REQ(N_REQ), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_fx(rsp_fx), .rsp_ready(rsp_ready),
    .core_x(core_x), .core_fx(core_fx),
    .busy(busy), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  // Stub core: registered bitwise inversion of its input.
  always @(posedge clk) core_fx <= core_x ^ 12'hFFF;

  function automatic int rr_pick(input logic [N_REQ-1:0] v, input int last);
    for (int k = 1; k <= N_REQ; k++)
      if (v[(last + k) % N_REQ]) return (last + k) % N_REQ;
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N_REQ-1:0] v);
    for (int i = 0; i < N_REQ; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic [N_REQ-1:0] v, input logic [N_REQ*DW-1:0] x,
                               input logic [N_REQ-1:0] r);
    @(posedge clk);
    #1;
    req_valid = v;
    req_x     = x;
    rsp_ready = r;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Per-cycle compare against the model, then advance the model across the coming edge.
  initial begin
    int p;
    logic [N_REQ-1:0] e_rr, e_rv;
    logic [DW-1:0]    e_fx;
    logic             e_busy;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_active = 1'b0;
        m_last   = N_REQ - 1;
        m_x      = '0;
        m_cnt    = '0;
        m_age    = 0;
      end
      e_rr = '0; e_rv = '0; e_fx = '0; e_busy = 1'b0; p = -1;
      if (rst_n && !m_active) begin
        p = rr_pick(req_valid, m_last);
        if (p >= 0) e_rr = N_REQ'(1) << p;
      end else if (rst_n) begin
        e_busy = 1'b1;
        if (m_age >= 3) begin
          e_rv = N_REQ'(1) << m_owner;
          e_fx = m_x ^ 12'hFFF;
        end
      end
      checkOutput("req_ready", req_ready, e_rr);
      checkOutput("rsp_valid", rsp_valid, e_rv);
      checkOutput("rsp_fx", rsp_fx, e_fx);
      checkOutput("busy", busy, e_busy);
      checkOutput("core_x", core_x, m_x);
      checkOutput("done_cnt", done_cnt, m_cnt);
      if (rst_n) begin
        if (!m_active && p >= 0) begin
          m_active = 1'b1;
          m_owner  = p;
          m_x      = req_x[p*DW +: DW];
          m_age    = 1;
        end else if (m_active) begin
          if (m_age >= 3 && rsp_ready[m_owner]) begin
            m_active = 1'b0;
            m_last   = m_owner;
            m_cnt    = m_cnt + 16'd1;
          end else begin
            m_age++;
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int g_ord[$];
    int g_cyc[$];
    logic [15:0] seen[$];
    logic [15:0] prev;
    bit first_rsp;
    logic [63:0] rnd;

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset values
    @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_core_x", core_x, 0);
    checkOutput("rst_done_cnt", done_cnt, 0);
    checkOutput("rst_req_ready", req_ready, 0);

    // Single request
    $display("[TB] single request");
    applyStimulus(4'b0001, 48'h000_000_000_123, 4'b1111);
    @(negedge clk);
    checkOutput("single_grant", req_ready, 4'b0001);
    applyStimulus(4'b0000, 48'h0, 4'b1111);
    repeat (3) @(negedge clk);
    checkOutput("single_rsp_valid", rsp_valid, 4'b0001);
    checkOutput("single_rsp_fx", rsp_fx, 12'hEDC);
    @(negedge clk);
    checkOutput("single_done_cnt", done_cnt, 1);

    // Fairness with all requesters continuously valid
    $display("[TB] fairness");
    doReset();
    applyStimulus(4'b1111, {12'h103, 12'h102, 12'h101, 12'h100}, 4'b1111);
    first_rsp = 1'b0;
    for (int c = 0; c < 40 && g_ord.size() < 5; c++) begin
      @(negedge clk);
      if (|(req_valid & req_ready)) begin
        g_ord.push_back(onehot_idx(req_ready));
        g_cyc.push_back(c);
      end
      if (!first_rsp && rsp_valid != '0) begin
        first_rsp = 1'b1;
        checkOutput("fair_first_rsp_valid", rsp_valid, 4'b0001);
        checkOutput("fair_first_rsp_fx", rsp_fx, 12'hEFF);
      end
    end
    checkOutput("fair_grant_count", g_ord.size(), 5);
    for (int i = 0; i < g_ord.size(); i++) begin
      checkOutput("fair_grant_order", g_ord[i], i % N_REQ);
      if (i > 0) checkOutput("fair_grant_spacing", g_cyc[i] - g_cyc[i-1], 4);
    end
    applyStimulus(4'b0000, 48'h0, 4'b1111);
    repeat (4) @(negedge clk);

    // Back-pressure on requester 2 while others wait
    $display("[TB] back-pressure");
    doReset();
    applyStimulus(4'b0100, 48'h000_2A5_000_000, 4'b0000);
    @(negedge clk);
    checkOutput("bp_grant", req_ready, 4'b0100);
    applyStimulus(4'b1011, 48'h777_2A5_555_444, 4'b0000);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("bp_rsp_valid", rsp_valid, 4'b0100);
      checkOutput("bp_rsp_fx", rsp_fx, 12'hD5A);
      checkOutput("bp_busy", busy, 1);
      checkOutput("bp_req_ready", req_ready, 0);
    end
    applyStimulus(4'b1011, 48'h777_2A5_555_444, 4'b0100);
    @(negedge clk);
    @(negedge clk);
    checkOutput("bp_release_busy", busy, 0);
    checkOutput("bp_next_grant", req_ready, 4'b1000);
    checkOutput("bp_done_cnt", done_cnt, 1);
    applyStimulus(4'b0000, 48'h0, 4'b1111);
    repeat (5) @(negedge clk);

    // Non-owner ready bits must not complete the transaction
    $display("[TB] wrong-owner ready");
    doReset();
    applyStimulus(4'b0010, 48'h000_000_3C0_000, 4'b1101);
    @(negedge clk);
    checkOutput("wo_grant", req_ready, 4'b0010);
    applyStimulus(4'b0000, 48'h0, 4'b1101);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("wo_rsp_valid", rsp_valid, 4'b0010);
      checkOutput("wo_done_cnt", done_cnt, 0);
    end
    applyStimulus(4'b0000, 48'h0, 4'b0010);
    @(negedge clk);
    @(negedge clk);
    checkOutput("wo_done_after", done_cnt, 1);
    checkOutput("wo_busy_after", busy, 0);

    // Reset asserted while the transaction is in CAPT
    $display("[TB] reset mid-flight");
    doReset();
    applyStimulus(4'b1000, 48'h456_000_000_000, 4'b0000);
    @(negedge clk);
    checkOutput("rmf_grant3", req_ready, 4'b1000);
    applyStimulus(4'b1001, 48'h456_000_000_0AB, 4'b0000);
    @(posedge clk);
    #1;
    checkOutput("rmf_busy_capt", busy, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rmf_busy", busy, 0);
    checkOutput("rmf_req_ready", req_ready, 0);
    checkOutput("rmf_rsp_valid", rsp_valid, 0);
    checkOutput("rmf_core_x", core_x, 0);
    checkOutput("rmf_done_cnt", done_cnt, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rmf_grant0_first", req_ready, 4'b0001);
    applyStimulus(4'b0000, 48'h0, 4'b1111);
    repeat (5) @(negedge clk);

    // Counter wrap, preloaded near the top
    $display("[TB] counter wrap");
    doReset();
    @(posedge clk);
    #2;
    force dut.cnt_q = 16'hFFFE;
    m_cnt = 16'hFFFE;
    #1;
    release dut.cnt_q;
    applyStimulus(4'b0001, 48'h000_000_000_055, 4'b1111);
    prev = 16'hFFFE;
    for (int c = 0; c < 30 && seen.size() < 2; c++) begin
      @(negedge clk);
      if (done_cnt != prev) begin
        seen.push_back(done_cnt);
        prev = done_cnt;
      end
    end
    checkOutput("wrap_changes", seen.size(), 2);
    if (seen.size() >= 1) checkOutput("wrap_ffff", seen[0], 16'hFFFF);
    if (seen.size() >= 2) checkOutput("wrap_zero", seen[1], 16'h0000);
    applyStimulus(4'b0000, 48'h0, 4'b1111);
    repeat (5) @(negedge clk);

    // Random traffic against the model
    $display("[TB] random traffic");
    doReset();
    for (int i = 0; i < 3000; i++) begin
      rnd = {$urandom, $urandom};
      applyStimulus(N_REQ'($urandom), rnd[N_REQ*DW-1:0], N_REQ'($urandom | $urandom));
    end
    applyStimulus(4'b0000, 48'h0, 4'b1111);
    repeat (6) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
